// File: rtl/coll_pkg.sv
// rtl/coll_pkg.sv - shared constants, state encoding and object record for the collision scheduler
package coll_pkg;

    localparam int W     = 32;
    localparam int N_OBJ = 8;
    localparam int IDX_W = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_EMIT  = 3'd3;
    localparam state_t ST_NEXT  = 3'd4;
    localparam state_t ST_FIN   = 3'd5;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] vx;
        logic [W-1:0] vy;
    } obj_t;

endpackage

// File: rtl/coll_pair_sched_if.sv
// rtl/coll_pair_sched_if.sv - table write, control, detector and hit-stream signals of the pair scheduler
interface coll_pair_sched_if
    import coll_pkg::*;
();
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [W-1:0]         wr_x, wr_y, wr_vx, wr_vy;
    logic [W-1:0]         r2;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [2*IDX_W-1:0]   hit_cnt;
    logic [W-1:0]         det_x1, det_y1, det_x2, det_y2;
    logic [W-1:0]         det_vx1, det_vy1, det_vx2, det_vy2, det_r2;
    logic                 det_in_rdy;
    logic                 det_out_rdy;
    logic                 det_trial;
    logic                 hit_valid;
    logic [IDX_W-1:0]     hit_i, hit_j;
    logic                 hit_ready;

    modport master (
        input  wr_en, wr_idx, wr_x, wr_y, wr_vx, wr_vy, r2, start,
        input  det_out_rdy, det_trial, hit_ready,
        output busy, done, err, hit_cnt,
        output det_x1, det_y1, det_x2, det_y2, det_vx1, det_vy1, det_vx2, det_vy2, det_r2,
        output det_in_rdy, hit_valid, hit_i, hit_j
    );

    modport slave (
        output wr_en, wr_idx, wr_x, wr_y, wr_vx, wr_vy, r2, start,
        output det_out_rdy, det_trial, hit_ready,
        input  busy, done, err, hit_cnt,
        input  det_x1, det_y1, det_x2, det_y2, det_vx1, det_vy1, det_vx2, det_vy2, det_r2,
        input  det_in_rdy, hit_valid, hit_i, hit_j
    );
endinterface

// File: rtl/coll_obj_table.sv
// rtl/coll_obj_table.sv - object register file, one write port and two combinational read ports
module coll_obj_table
    import coll_pkg::*;
(
    input  logic             clock,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  obj_t             wr_data,
    input  logic [IDX_W-1:0] rd_i,
    input  logic [IDX_W-1:0] rd_j,
    output obj_t             rd_data_i,
    output obj_t             rd_data_j
);
    obj_t mem [N_OBJ];

    // Contents deliberately survive reset so a reload is not needed after an abort.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data_i = mem[rd_i];
    assign rd_data_j = mem[rd_j];
endmodule

// File: rtl/coll_pair_sched.sv
// rtl/coll_pair_sched.sv - walks all i<j object pairs through the collision detector and streams hits
module coll_pair_sched
    import coll_pkg::*;
#(
    parameter int TMO = 31
) (
    input logic              clock,
    input logic              reset,
    coll_pair_sched_if.master bus
);
    localparam int TW = $clog2(TMO + 1);

    state_t             state;
    logic [IDX_W-1:0]   i, j;
    logic [TW-1:0]      tmo_cnt;
    obj_t               op1, op2, obj_i, obj_j;
    logic [W-1:0]       r2_q;
    logic               err_q;
    logic [2*IDX_W-1:0] hit_cnt_q;
    logic [IDX_W-1:0]   hit_i_q, hit_j_q;

    coll_obj_table u_table (
        .clock     (clock),
        .wr_en     (bus.wr_en && state == ST_IDLE),
        .wr_idx    (bus.wr_idx),
        .wr_data   ({bus.wr_x, bus.wr_y, bus.wr_vx, bus.wr_vy}),
        .rd_i      (i),
        .rd_j      (j),
        .rd_data_i (obj_i),
        .rd_data_j (obj_j)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            i         <= '0;
            j         <= '0;
            tmo_cnt   <= '0;
            op1       <= '0;
            op2       <= '0;
            r2_q      <= '0;
            err_q     <= 1'b0;
            hit_cnt_q <= '0;
            hit_i_q   <= '0;
            hit_j_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    r2_q      <= bus.r2;
                    i         <= '0;
                    j         <= IDX_W'(1);
                    err_q     <= 1'b0;
                    hit_cnt_q <= '0;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    op1     <= obj_i;
                    op2     <= obj_j;
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.det_out_rdy) begin
                        if (bus.det_trial) begin
                            hit_i_q <= i;
                            hit_j_q <= j;
                            state   <= ST_EMIT;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end else if (tmo_cnt == TW'(TMO - 1)) begin
                        // Abandoned pair counts as a miss; the sweep carries on.
                        err_q <= 1'b1;
                        state <= ST_NEXT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_EMIT: if (bus.hit_ready) begin
                    if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (j < IDX_W'(N_OBJ - 1)) begin
                        j     <= j + 1'b1;
                        state <= ST_ISSUE;
                    end else if (i < IDX_W'(N_OBJ - 2)) begin
                        i     <= i + 1'b1;
                        j     <= i + IDX_W'(2);
                        state <= ST_ISSUE;
                    end else begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state == ST_ISSUE) || (state == ST_WAIT) ||
                            (state == ST_EMIT)  || (state == ST_NEXT);
    assign bus.done       = (state == ST_FIN);
    assign bus.det_in_rdy = (state == ST_WAIT);
    assign bus.hit_valid  = (state == ST_EMIT);
    assign bus.err        = err_q;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.hit_i      = hit_i_q;
    assign bus.hit_j      = hit_j_q;
    assign bus.det_x1     = op1.x;
    assign bus.det_y1     = op1.y;
    assign bus.det_vx1    = op1.vx;
    assign bus.det_vy1    = op1.vy;
    assign bus.det_x2     = op2.x;
    assign bus.det_y2     = op2.y;
    assign bus.det_vx2    = op2.vx;
    assign bus.det_vy2    = op2.vy;
    assign bus.det_r2     = r2_q;
endmodule

// File: doc/coll_pair_sched.md
Name: coll_pair_sched

Overview:
- Upstream scheduler for the collision detector.
- Holds a table of N_OBJ objects (position, velocity) and walks every unordered pair (i<j).
- For each pair it presents the operands to the detector, waits for the result, and streams the indices of colliding pairs to a downstream consumer under valid/ready backpressure.

Parameters:
- W, 32, operand width of position/velocity/r2 (matches detector datapath)
- N_OBJ, 8, number of table entries (≥2)
- IDX_W, 3, index width, = clog2(N_OBJ)
- TMO, 31, max cycles to wait for det_out_rdy before abandoning a pair

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  table write strobe (honoured only in IDLE)
- wr_idx  in  IDX_W  entry to write
- wr_x, wr_y, wr_vx, wr_vy  in  W each  object fields
- r2  in  W  collision threshold (sum of radii squared); sampled on start
- start  in  1  begin a full pair sweep (honoured only in IDLE)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes
- err  out  1  sticky: at least one pair timed out in this sweep
- hit_cnt  out  IDX_W*2  number of hits in the current/last sweep
- det_x1, det_y1, det_x2, det_y2, det_vx1, det_vy1, det_vx2, det_vy2, det_r2  out  W each  detector operands
- det_in_rdy  out  1  detector operands valid
- det_out_rdy  in  1  detector result valid (single-cycle pulse)
- det_trial  in  1  detector result: 1 = collision
- hit_valid  out  1  hit record valid
- hit_i, hit_j  out  IDX_W each  colliding pair, hit_i < hit_j
- hit_ready  in  1  consumer accepts hit

Behaviour:
- Reset values:
  - FSM = IDLE; busy, done, err, det_in_rdy, hit_valid = 0; hit_cnt = 0.
  - All det_* operand outputs = 0; hit_i, hit_j = 0.
  - Table contents are not reset.
- Table writes:
  - Accepted only in IDLE; writes in any other state are dropped silently.
  - A write and a start in the same cycle: the write lands first; the sweep sees the new data.
- FSM states: IDLE, ISSUE, WAIT, EMIT, NEXT, FIN.
- IDLE
  - On start: latch r2 into det_r2; set i=0, j=1; clear err and hit_cnt; busy=1; go to ISSUE.
  - start while busy is ignored.
- ISSUE (1 cycle)
  - Drive det_x1..det_vy1 from table[i] and det_x2..det_vy2 from table[j].
  - Set det_in_rdy=1; clear timeout counter; go to WAIT.
- WAIT
  - det_in_rdy and all operands held stable.
  - On det_out_rdy: drop det_in_rdy; go to EMIT if det_trial=1, else NEXT.
  - If the counter reaches TMO with no det_out_rdy: drop det_in_rdy, set err=1, go to NEXT (pair treated as no hit).
  - det_out_rdy in any state other than WAIT is ignored.
- EMIT
  - hit_valid=1, hit_i=i, hit_j=j; all three held until hit_ready.
  - On the cycle hit_valid & hit_ready: hit_cnt += 1, hit_valid=0, go to NEXT.
- NEXT (1 cycle)
  - If j < N_OBJ-1: j += 1.
  - Else if i < N_OBJ-2: i += 1, j = i+2 (new i + 1).
  - Else go to FIN.
  - Otherwise go to ISSUE.
- FIN
  - done=1 for exactly one cycle, busy=0, go to IDLE.
  - err and hit_cnt hold until the next start.
- Pair order: (0,1),(0,2)…(0,N-1),(1,2)…(N-2,N-1); total N(N-1)/2 = 28 pairs for N=8.
- Latency per non-hit pair = 3 + detector latency cycles (ISSUE, WAIT…, NEXT).
- hit_cnt saturates at all-ones; no wrap.
- Reset asserted mid-sweep: return to IDLE next edge with the reset values above. No hit or done is emitted for the aborted sweep.
- Arithmetic: operands pass through unchanged. No sign handling in this block; the detector interprets the values.

Decomposition:
- Shared package coll_pkg:
  - constants W, N_OBJ, IDX_W
  - FSM state enum
  - object struct {x, y, vx, vy}, also used by the detector wrapper
- One natural sub-module: coll_obj_table, a N_OBJ × 4W register file with a write port and two combinational read ports (i, j).
- The FSM and index counters stay in the top module.

Test Plan:
- Load 8 objects spaced 100 apart on x, all v=0, r2=25, detector model never hits; start → exactly 28 det_in_rdy handshakes in the listed order, done pulse once, hit_cnt=0, err=0.
- Detector model returns trial=1 only for pair (2,5) → single hit record hit_i=2, hit_j=5, hit_cnt=1.
- Hit on (0,1) with hit_ready held low 10 cycles → hit_valid and indices stable all 10 cycles; no new det_in_rdy until accepted.
- Detector never responds for pair (3,4), TMO=31 → WAIT lasts 31 cycles, err=1, sweep continues to (3,5), done still pulses after 28 pairs.
- wr_en to idx 6 during busy, plus start during busy → table[6] unchanged after the sweep; sweep not restarted.
- reset pulse while in WAIT of pair (1,3) → next cycle busy=0, det_in_rdy=0, hit_valid=0, hit_cnt=0; a subsequent start sweeps from (0,1).
